// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame constants and baud divisor lookup.
package uart_pkg;

  localparam int DATA_W     = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int baud_rate(input logic [1:0] sel);
    case (sel)
      2'd0:    return 9600;
      2'd1:    return 19200;
      2'd2:    return 57600;
      default: return 115200;
    endcase
  endfunction

  // Rounded clk_hz / (OVERSAMPLE * baud), integer-only so it folds at elaboration.
  function automatic int baud_divisor(input int clk_hz, input logic [1:0] sel);
    int os_baud;
    os_baud = OVERSAMPLE * baud_rate(sel);
    return (clk_hz + os_baud / 2) / os_baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO with show-ahead registered head, level output and registered threshold flag.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  input  logic [LVL_W-1:0]  i_thresh,
  output logic [DATA_W-1:0] o_head,
  output logic              o_valid,
  output logic              o_full_thr,
  output logic [LVL_W-1:0]  o_level
);

  localparam int                PTR_W    = $clog2(DEPTH);
  localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_head;
  logic              r_full_thr;

  logic              w_do_pop;
  logic              w_do_push;
  logic              w_push_is_head;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [LVL_W-1:0]  w_level_nxt;

  // A full FIFO still accepts a push when the same cycle pops a slot free.
  assign w_do_pop       = i_pop && (r_level != '0);
  assign w_do_push      = i_push && ((r_level != LVL_FULL) || w_do_pop);
  assign w_rd_nxt       = r_rd_ptr + PTR_W'(w_do_pop);
  assign w_level_nxt    = r_level + LVL_W'(w_do_push) - LVL_W'(w_do_pop);
  assign w_push_is_head = w_do_push && (r_level == LVL_W'(w_do_pop));

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_head     <= '0;
      r_full_thr <= 1'b0;
    end else begin
      r_wr_ptr   <= r_wr_ptr + PTR_W'(w_do_push);
      r_rd_ptr   <= w_rd_nxt;
      r_level    <= w_level_nxt;
      r_full_thr <= (w_level_nxt >= i_thresh);
      // Head holds its last value once the FIFO drains.
      if (w_push_is_head)
        r_head <= i_data;
      else if (w_do_pop && (w_level_nxt != '0))
        r_head <= r_mem[w_rd_nxt];
    end
  end

  assign o_head     = r_head;
  assign o_valid    = (r_level != '0);
  assign o_full_thr = r_full_thr;
  assign o_level    = r_level;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-FF synchroniser, 16x oversampling prescaler, frame FSM and receive FIFO.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FIFO_DEPTH  = 16,
  parameter int LVL_W       = 5
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              uart_rx_i,
  input  logic [1:0]        baudrate_select_i,
  input  logic [LVL_W-1:0]  data_buffer_full_tresh_i,
  input  logic              data_read_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_valid_o,
  output logic              data_buffer_full_o,
  output logic              frame_error_o,
  output logic              overrun_error_o
);

  localparam logic [DIV_W-1:0] DIV0 = DIV_W'(baud_divisor(CLK_FREQ_HZ, 2'd0));
  localparam logic [DIV_W-1:0] DIV1 = DIV_W'(baud_divisor(CLK_FREQ_HZ, 2'd1));
  localparam logic [DIV_W-1:0] DIV2 = DIV_W'(baud_divisor(CLK_FREQ_HZ, 2'd2));
  localparam logic [DIV_W-1:0] DIV3 = DIV_W'(baud_divisor(CLK_FREQ_HZ, 2'd3));

  logic              r_rx_meta;
  logic              r_rx_s;
  logic              r_rx_prev;
  rx_state_t         r_state;
  rx_state_t         w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [DIV_W-1:0]  r_presc;
  logic [3:0]        r_tick_cnt;
  logic [2:0]        r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic              r_frame_err;
  logic              r_overrun;

  logic [DIV_W-1:0]  w_div_sel;
  logic              w_tick;
  logic              w_fall;
  logic              w_start_sample;
  logic              w_sample_bit;
  logic              w_stop_sample;
  logic              w_push;
  logic              w_frame_err;
  logic [LVL_W-1:0]  w_level;

  always_comb begin
    w_div_sel = DIV3;
    case (baudrate_select_i)
      2'd0:    w_div_sel = DIV0;
      2'd1:    w_div_sel = DIV1;
      2'd2:    w_div_sel = DIV2;
      default: w_div_sel = DIV3;
    endcase
  end

  assign w_fall = r_rx_prev & ~r_rx_s;
  assign w_tick = (r_state != IDLE) && (r_presc == r_div - DIV_W'(1));

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= uart_rx_i;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_fall) w_state_nxt = START;
      START:   if (w_start_sample) w_state_nxt = r_rx_s ? IDLE : DATA;
      DATA:    if (w_sample_bit && (r_bit_cnt == 3'd7)) w_state_nxt = STOP;
      STOP:    if (w_stop_sample) w_state_nxt = r_rx_s ? IDLE : BREAK;
      BREAK:   if (r_rx_s) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_start_sample = 1'b0;
    w_sample_bit   = 1'b0;
    w_stop_sample  = 1'b0;
    case (r_state)
      START:   w_start_sample = w_tick && (r_tick_cnt == 4'd7);
      DATA:    w_sample_bit   = w_tick && (r_tick_cnt == 4'd15);
      STOP:    w_stop_sample  = w_tick && (r_tick_cnt == 4'd15);
      default: ;
    endcase
    w_push      = w_stop_sample & r_rx_s;
    w_frame_err = w_stop_sample & ~r_rx_s;
  end

  // Divisor is frozen for the whole frame; the tick counter wraps 15->0 between data bits.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_div       <= DIV0;
      r_presc     <= '0;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (r_state == IDLE) r_div <= w_div_sel;

      if ((r_state == IDLE) || w_tick) r_presc <= '0;
      else                             r_presc <= r_presc + DIV_W'(1);

      if ((r_state == IDLE) || w_start_sample) r_tick_cnt <= '0;
      else if (w_tick)                         r_tick_cnt <= r_tick_cnt + 4'd1;

      if (r_state != DATA)   r_bit_cnt <= '0;
      else if (w_sample_bit) r_bit_cnt <= r_bit_cnt + 3'd1;

      r_frame_err <= w_frame_err;
      r_overrun   <= w_push && (w_level == LVL_W'(FIFO_DEPTH)) && !data_read_i;
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_sample_bit) r_shift[r_bit_cnt] <= r_rx_s;
  end

  uart_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .i_clk      (clock_i),
    .i_rst_n    (reset_n_i),
    .i_push     (w_push),
    .i_data     (r_shift),
    .i_pop      (data_read_i),
    .i_thresh   (data_buffer_full_tresh_i),
    .o_head     (data_o),
    .o_valid    (data_valid_o),
    .o_full_thr (data_buffer_full_o),
    .o_level    (w_level)
  );

  assign frame_error_o   = r_frame_err;
  assign overrun_error_o = r_overrun;

endmodule
